// File: rtl/port_send_scheduler.sv
// port_send_scheduler: per-input-port frame scheduler for the nxn switch.
// Arbitrates REQ_NUB requesters (priority, round-robin tie-break) and emits
// one header beat followed by L payload beats per granted request.
// Optional statistics counters: define PORT_SEND_SCHED_STATS_EN.
module port_send_scheduler #(
  parameter int unsigned REQ_NUB         = 4,
  parameter int unsigned PORT_NUB        = 4,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned PRIORITY        = 8,
  parameter int unsigned DATA_LENGTH_MAX = 256,
  parameter int unsigned TX_PORT         = 0,
  localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUB),
  localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY),
  localparam int unsigned WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [REQ_NUB-1:0]               req_i,
  input  logic [REQ_NUB*WIDTH_SEL-1:0]     req_dest_i,
  input  logic [REQ_NUB*WIDTH_PRIORITY-1:0] req_pri_i,
  input  logic [REQ_NUB*WIDTH_LENGTH-1:0]  req_len_i,
  output logic [REQ_NUB-1:0]               ack_o,
  input  logic                             full_i,
  input  logic                             alm_ost_full_i,
  output logic                             wr_sop_o,
  output logic                             wr_eop_o,
  output logic                             wr_vld_o,
  output logic [DATA_WIDTH-1:0]            wr_data_o,
  output logic                             busy_o
`ifdef PORT_SEND_SCHED_STATS_EN
  ,
  output logic [31:0]                      frame_cnt_o,
  output logic [31:0]                      beat_cnt_o,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int unsigned WIDTH_REQ = (REQ_NUB > 1) ? $clog2(REQ_NUB) : 1;
  localparam logic [WIDTH_SEL-1:0] TXP = WIDTH_SEL'(TX_PORT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [WIDTH_REQ-1:0]      rr_q, rr_d;
  logic [WIDTH_LENGTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH_SEL-1:0]      dest_q, dest_d;
  logic [WIDTH_PRIORITY-1:0] pri_q, pri_d;
  logic [WIDTH_LENGTH-1:0]   len_q, len_d;
  logic [REQ_NUB-1:0]        ack_q, ack_d;
  logic                      sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      busy_q, busy_d;

  logic [WIDTH_SEL-1:0]      dest_arr [REQ_NUB];
  logic [WIDTH_PRIORITY-1:0] pri_arr  [REQ_NUB];
  logic [WIDTH_LENGTH-1:0]   len_arr  [REQ_NUB];

  logic                      win_found;
  logic [WIDTH_REQ-1:0]      win_idx;
  logic [WIDTH_PRIORITY-1:0] win_pri;
  logic [WIDTH_REQ:0]        ksum;
  logic [WIDTH_REQ-1:0]      k;

  // Unpack the flat descriptor buses into per-requester fields
  always_comb begin
    for (int unsigned i = 0; i < REQ_NUB; i++) begin
      dest_arr[i] = req_dest_i[i*WIDTH_SEL +: WIDTH_SEL];
      pri_arr[i]  = req_pri_i[i*WIDTH_PRIORITY +: WIDTH_PRIORITY];
      len_arr[i]  = req_len_i[i*WIDTH_LENGTH +: WIDTH_LENGTH];
    end
  end

  // Highest priority wins; scanning from rr_q with strict '>' gives the tie-break
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    ksum      = '0;
    k         = '0;
    for (int unsigned j = 0; j < REQ_NUB; j++) begin
      ksum = {1'b0, rr_q} + (WIDTH_REQ+1)'(j);
      if (ksum >= (WIDTH_REQ+1)'(REQ_NUB)) ksum = ksum - (WIDTH_REQ+1)'(REQ_NUB);
      k = ksum[WIDTH_REQ-1:0];
      if (req_i[k] && (!win_found || (pri_arr[k] > win_pri))) begin
        win_found = 1'b1;
        win_idx   = k;
        win_pri   = pri_arr[k];
      end
    end
  end

  // Next-state and next-output logic for the frame builder
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    pri_d   = pri_q;
    len_d   = len_q;
    ack_d   = '0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    vld_d   = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q & ~eop_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !alm_ost_full_i) begin
          dest_d  = dest_arr[win_idx];
          pri_d   = pri_arr[win_idx];
          len_d   = len_arr[win_idx];
          ack_d   = REQ_NUB'(1) << win_idx;
          rr_d    = (win_idx == WIDTH_REQ'(REQ_NUB-1)) ? '0 : win_idx + WIDTH_REQ'(1);
          busy_d  = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!full_i) begin
          vld_d  = 1'b1;
          sop_d  = 1'b1;
          data_d = DATA_WIDTH'({len_q, pri_q, dest_q});
          cnt_d  = '0;
          if (len_q == '0) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (!full_i) begin
          vld_d  = 1'b1;
          data_d = {TXP, (DATA_WIDTH-WIDTH_SEL)'(cnt_q)};
          cnt_d  = cnt_q + WIDTH_LENGTH'(1);
          if (cnt_q == len_q - WIDTH_LENGTH'(1)) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      pri_q   <= '0;
      len_q   <= '0;
      ack_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      pri_q   <= pri_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_o     = ack_q;
  assign wr_sop_o  = sop_q;
  assign wr_eop_o  = eop_q;
  assign wr_vld_o  = vld_q;
  assign wr_data_o = data_q;
  assign busy_o    = busy_q;

`ifdef PORT_SEND_SCHED_STATS_EN
  logic [31:0] frame_cnt_q, beat_cnt_q, stall_cnt_q;
  logic        stall_now;

  assign stall_now = ((state_q == ST_HDR) || (state_q == ST_PAY)) && full_i;

  // Saturating frame / beat / stall counters, counted as beats are issued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (eop_d && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (vld_d && (beat_cnt_q != '1))  beat_cnt_q  <= beat_cnt_q + 32'd1;
      if (stall_now && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_port_send_scheduler.sv
// Directed self-checking bench for port_send_scheduler (default parameters).
module tb_port_send_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_dest;
  logic [11:0] req_pri;
  logic [31:0] req_len;
  logic [3:0]  ack;
  logic        full, alm;
  logic        wr_sop, wr_eop, wr_vld, busy;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  port_send_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .req_dest_i     (req_dest),
    .req_pri_i      (req_pri),
    .req_len_i      (req_len),
    .ack_o          (ack),
    .full_i         (full),
    .alm_ost_full_i (alm),
    .wr_sop_o       (wr_sop),
    .wr_eop_o       (wr_eop),
    .wr_vld_o       (wr_vld),
    .wr_data_o      (wr_data),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int i, input int dest, input int pri, input int len);
    req_dest[i*2 +: 2] = 2'(dest);
    req_pri[i*3 +: 3]  = 3'(pri);
    req_len[i*8 +: 8]  = 8'(len);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"},  32'(ack), 0);
    chk({tag, "_vld"},  32'(wr_vld), 0);
    chk({tag, "_sop"},  32'(wr_sop), 0);
    chk({tag, "_eop"},  32'(wr_eop), 0);
    chk({tag, "_data"}, 32'(wr_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Follow one frame from grant to eop (or to beat abort_at), checking each beat
  task automatic run_frame(input string tag, input logic [3:0] exp_ack, input logic [15:0] exp_hdr,
                           input int len, input int stall_at, input int stall_n,
                           input int abort_at, input bit drop_ack);
    int beat = 0, cyc = 0, stall_left = 0, nbub = 0, nack = 0;
    logic [3:0]  ack_got = '0;
    logic [15:0] last_data = '0;
    logic [15:0] exp_data;
    bit done = 1'b0;
    while (!done) begin
      tick();
      cyc++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) full = 1'b0;
      end
      if (ack != 4'b0) begin
        ack_got = ack;
        nack++;
        if (drop_ack) req = req & ~ack;
      end
      if (wr_vld) begin
        exp_data = (beat == 0) ? exp_hdr : 16'(beat - 1);
        chk($sformatf("%s_b%0d_data", tag, beat), 32'(wr_data), 32'(exp_data));
        chk($sformatf("%s_b%0d_sop", tag, beat), 32'(wr_sop), 32'(beat == 0));
        chk($sformatf("%s_b%0d_eop", tag, beat), 32'(wr_eop), 32'(beat == len));
        last_data = wr_data;
        if (wr_eop) begin
          chk({tag, "_eop_busy"}, 32'(busy), 1);
          if (abort_at < 0) done = 1'b1;
        end
        if (beat == abort_at) done = 1'b1;
        if (beat == stall_at) begin
          full = 1'b1;
          stall_left = stall_n;
        end
        beat++;
      end else if (beat > 0) begin
        nbub++;
        chk({tag, "_hold"}, 32'(wr_data), 32'(last_data));
      end
      if (cyc >= 600 && !done) begin
        chk({tag, "_timeout_cycles"}, 32'(cyc), 0);
        done = 1'b1;
      end
    end
    chk({tag, "_ack"}, 32'(ack_got), 32'(exp_ack));
    if (abort_at < 0) begin
      chk({tag, "_ack_pulses"}, 32'(nack), 1);
      chk({tag, "_beats"}, 32'(beat), 32'(len + 1));
      chk({tag, "_bubbles"}, 32'(nbub), 32'(stall_n));
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_dest = '0; req_pri = '0; req_len = '0;
    full = 1'b0; alm = 1'b0;
    tick(); tick();
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Single requester, dest=2 pri=3 len=4 -> header 0x008E
    set_desc(0, 2, 3, 4);
    req = 4'b0001;
    run_frame("basic", 4'b0001, 16'h008E, 4, -1, 0, -1, 1'b1);
    tick();
    chk("basic_busy_after", 32'(busy), 0);
    chk("basic_vld_after", 32'(wr_vld), 0);

    // Equal priority round-robin: 1, 3, 1 with req held
    set_desc(1, 1, 5, 2);
    set_desc(3, 3, 5, 1);
    req = 4'b1010;
    run_frame("rr1", 4'b0010, 16'h0055, 2, -1, 0, -1, 1'b0);
    run_frame("rr2", 4'b1000, 16'h0037, 1, -1, 0, -1, 1'b0);
    run_frame("rr3", 4'b0010, 16'h0055, 2, -1, 0, -1, 1'b0);
    req = 4'b0000;

    // Strict priority: requester 0 (pri 7) beats requester 1 (pri 2)
    set_desc(0, 2, 7, 1);
    set_desc(1, 0, 2, 1);
    req = 4'b0011;
    run_frame("pri_a", 4'b0001, 16'h003E, 1, -1, 0, -1, 1'b0);
    run_frame("pri_b", 4'b0001, 16'h003E, 1, -1, 0, -1, 1'b0);
    req[0] = 1'b0;
    run_frame("pri_c", 4'b0010, 16'h0028, 1, -1, 0, -1, 1'b1);

    // Zero-length frame: single beat, busy drops the next cycle
    set_desc(2, 1, 0, 0);
    req = 4'b0100;
    run_frame("len0", 4'b0100, 16'h0001, 0, -1, 0, -1, 1'b1);
    tick();
    chk("len0_busy_after", 32'(busy), 0);

    // len=8 with full high for 3 cycles after beat 2
    set_desc(3, 0, 4, 8);
    req = 4'b1000;
    run_frame("stall", 4'b1000, 16'h0110, 8, 2, 3, -1, 1'b1);

    // alm_ost_full in IDLE blocks the grant
    set_desc(0, 1, 6, 2);
    alm = 1'b1;
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("alm_noack_%0d", c), 32'(ack), 0);
      chk($sformatf("alm_nobusy_%0d", c), 32'(busy), 0);
    end
    alm = 1'b0;
    run_frame("alm", 4'b0001, 16'h0059, 2, -1, 0, -1, 1'b1);

    // Reset during payload beat 3 of a len=10 frame, then fresh frame
    set_desc(1, 3, 1, 10);
    req = 4'b0010;
    run_frame("abort", 4'b0010, 16'h0147, 10, -1, 0, 4, 1'b0);
    rst = 1'b1;
    tick();
    chk_idle_outputs("midrst");
    rst = 1'b0;
    run_frame("restart", 4'b0010, 16'h0147, 10, -1, 0, -1, 1'b1);
    tick();
    chk("restart_busy_after", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/port_send_scheduler.md
Name: port_send_scheduler

Overview:
Per-input-port scheduler for the nxn switch. It arbitrates among REQ_NUB local traffic requesters that share one switch write port. It builds each granted request into a wr_sop/wr_vld/wr_eop frame: one header beat, then length payload beats. Frame starts are gated on alm_ost_full and individual beats are stalled on full.

Parameters:
REQ_NUB, 4, number of requesters sharing the port
PORT_NUB, 4, switch port count; WIDTH_SEL = $clog2(PORT_NUB)
DATA_WIDTH, 16, switch data width
PRIORITY, 8, priority levels; WIDTH_PRIORITY = $clog2(PRIORITY)
DATA_LENGTH_MAX, 256, length range; WIDTH_LENGTH = $clog2(DATA_LENGTH_MAX)
TX_PORT, 0, this port's index, embedded in payload

Ports:
clk  in  1  single clock (external 250 MHz domain)
rst  in  1  synchronous, active-high reset
req  in  REQ_NUB  request per requester; held until ack
req_dest  in  REQ_NUB*WIDTH_SEL  destination port, slice i = requester i
req_pri  in  REQ_NUB*WIDTH_PRIORITY  priority; larger value = higher priority
req_len  in  REQ_NUB*WIDTH_LENGTH  payload beat count L (0 allowed)
ack  out  REQ_NUB  one-cycle pulse, one-hot, when the descriptor is captured
full  in  1  switch full; a beat is not issued while high
alm_ost_full  in  1  switch almost full; no new frame starts while high
wr_sop  out  1  frame start, coincident with header beat
wr_eop  out  1  frame end, coincident with last beat
wr_vld  out  1  beat valid
wr_data  out  DATA_WIDTH  header/payload word
busy  out  1  high from grant until the cycle after the eop beat

Behaviour:
- Reset (sync, rst=1 at edge): all outputs 0, state IDLE, rr_ptr=0, beat counter 0. A mid-frame reset truncates the frame with no eop. The switch side tolerates this.
- All outputs are registered. A beat appears on wr_* in cycle n+1 only if full=0 in cycle n. When full=1, the next cycle has wr_vld=wr_sop=wr_eop=0 and wr_data holds its value.
- States:
  - IDLE: if any req=1 and alm_ost_full=0, pick the winner, capture dest/pri/len, pulse ack[winner] next cycle, busy=1, go to HDR. Otherwise stay.
  - HDR: on full=0, issue the header with wr_sop=1. If L=0, also set wr_eop=1 and go to IDLE. Otherwise go to PAY with cnt=0.
  - PAY: on full=0, issue payload word cnt and increment cnt. When cnt=L-1, set wr_eop=1 and go to IDLE.
- Arbitration: the highest req_pri among asserted req wins. Ties go to the first asserted index at or after rr_ptr, modulo REQ_NUB. After a grant, rr_ptr = winner+1 (wraps REQ_NUB-1 -> 0).
- Header word (LSB first): dest[WIDTH_SEL-1:0], then pri, then len, zero-padded to DATA_WIDTH.
- Payload word k = {TX_PORT[WIDTH_SEL-1:0], k zero-extended to DATA_WIDTH-WIDTH_SEL}, k = 0..L-1.
- Frame length is L+1 beats. The minimum is 1 beat (sop=eop=vld=1). The maximum is DATA_LENGTH_MAX beats.
- Back-to-back frames: the earliest next wr_sop is 2 cycles after eop (eop -> IDLE -> HDR).
- alm_ost_full is sampled only in IDLE. An assertion mid-frame does not stall the frame; only full stalls beats.
- A requester dropping req before ack: the descriptor was already captured at grant, so the frame is still sent and ack is still pulsed.
- A descriptor change after ack has no effect on the current frame.

Optional Feature:
PORT_SEND_SCHED_STATS_EN:
- Defined: adds outputs frame_cnt[31:0], beat_cnt[31:0] and stall_cnt[31:0].
  - frame_cnt increments on each eop beat.
  - beat_cnt increments on each vld beat.
  - stall_cnt increments on each HDR/PAY cycle with full=1.
  - All three saturate at max and clear on rst.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- req=4'b0001, pri0=3, dest0=2, len0=4, full=0 -> ack[0] pulse; 5 beats; header=0x008E (dest=2, pri=3, len=4); payload 0x0000..0x0003 (TX_PORT=0); sop on beat 0, eop on beat 4.
- req=4'b1010, pri1=pri3=5, 3 rounds with req held -> grants alternate 1, 3, 1 (round-robin tie-break); each frame well-formed.
- req=4'b0011, pri0=7, pri1=2 -> requester 0 wins repeatedly while held; requester 1 is served only after req[0] drops.
- len=0 -> single beat with wr_sop=wr_eop=wr_vld=1; busy drops the following cycle.
- len=8, full forced high for 3 cycles after beat 2 -> exactly 3 bubble cycles, data sequence unbroken, total 9 beats; alm_ost_full=1 in IDLE with req=1 -> no ack until it drops.
- rst=1 at payload beat 3 of a len=10 frame -> next cycle all outputs 0, state IDLE; after rst=0 with req held, a fresh frame starts from the header.
